// File: rtl/cache_controller_if.sv
// CPU-side request/response and memory-side refill/write-through signals
// of the cache controller, grouped as one bundle.
interface cache_controller_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        cpu_hit;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ready, cpu_hit,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ready, cpu_hit,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );
endinterface

// File: rtl/cache_controller.sv
// 4-way set-associative write-through, no-write-allocate cache controller.
// Round-robin replacement by default; true LRU when CACHE_LRU_EN is defined.
module cache_controller #(
   parameter int NSETS = 256
) (
   input logic               clk,
   input logic               rst_n,
   cache_controller_if.slave bus
);
   localparam int IW = $clog2(NSETS);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOOKUP = 2'd1;
   localparam logic [1:0] MEM    = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   logic [1:0]    state_q;
   logic          we_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [1:0]    way_q;
   logic          hit_q;

   logic [IW-1:0] idx;
   logic [21:0]   tag;

   logic [3:0]    valid_q [NSETS];
   logic [21:0]   tag_q   [4][NSETS];
   logic [31:0]   data_q  [4][NSETS];

   logic [3:0]    match;
   logic          hit;
   logic [1:0]    hit_way;
   logic [31:0]   hit_data;
   logic [1:0]    victim;
   logic [1:0]    repl_way;
   logic          refill;
   logic          touch;
   logic [1:0]    touch_way;
   logic          unused_bits;

   assign idx       = addr_q[2 +: IW];
   assign tag       = addr_q[31:10];
   assign hit       = |match;
   assign refill    = (state_q == MEM) && bus.mem_ready && !we_q;
   assign touch     = refill || ((state_q == LOOKUP) && hit);
   assign touch_way = (state_q == LOOKUP) ? hit_way : way_q;

   always_comb begin
      match    = '0;
      hit_way  = '0;
      hit_data = '0;
      for (int w = 0; w < 4; w++) begin
         match[w] = valid_q[idx][w] && (tag_q[w][idx] == tag);
         if (match[w]) begin
            hit_way  = 2'(w);
            hit_data = data_q[w][idx];
         end
      end
   end

   // Lowest-index invalid way wins over the replacement policy.
   always_comb begin
      victim = repl_way;
      for (int w = 3; w >= 0; w--) begin
         if (!valid_q[idx][w]) victim = 2'(w);
      end
   end

`ifdef CACHE_LRU_EN
   logic [7:0] age_q [NSETS];

   // Ages at or below the touched way's age move one step older (saturating),
   // so ages settle into a recency ranking even from the all-zero reset.
   function automatic logic [7:0] lru_touch(input logic [7:0] a,
                                            input logic [1:0] w);
      logic [1:0] acc;
      lru_touch = a;
      acc = a[2*w +: 2];
      for (int i = 0; i < 4; i++) begin
         if (2'(i) != w && a[2*i +: 2] <= acc && a[2*i +: 2] != 2'd3)
            lru_touch[2*i +: 2] = a[2*i +: 2] + 2'd1;
      end
      lru_touch[2*w +: 2] = 2'd0;
   endfunction

   always_comb begin
      logic [1:0] oldest;
      repl_way = '0;
      oldest   = age_q[idx][1:0];
      for (int w = 1; w < 4; w++) begin
         if (age_q[idx][2*w +: 2] > oldest) begin
            oldest   = age_q[idx][2*w +: 2];
            repl_way = 2'(w);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NSETS; s++) age_q[s] <= '0;
      end else if (touch) begin
         age_q[idx] <= lru_touch(age_q[idx], touch_way);
      end
   end

   assign unused_bits = ^addr_q[1:0];
`else
   logic [1:0] ptr_q [NSETS];

   assign repl_way = ptr_q[idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NSETS; s++) ptr_q[s] <= '0;
      end else if (refill) begin
         ptr_q[idx] <= ptr_q[idx] + 2'd1;
      end
   end

   assign unused_bits = ^{addr_q[1:0], touch, touch_way};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         way_q         <= '0;
         hit_q         <= 1'b0;
         bus.cpu_ready <= 1'b0;
         bus.cpu_hit   <= 1'b0;
         bus.cpu_rdata <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         for (int s = 0; s < NSETS; s++) valid_q[s] <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.cpu_req) begin
                  we_q    <= bus.cpu_we;
                  addr_q  <= bus.cpu_addr;
                  wdata_q <= bus.cpu_wdata;
                  state_q <= LOOKUP;
               end
            end
            LOOKUP: begin
               hit_q <= hit;
               way_q <= hit ? hit_way : victim;
               if (!we_q && hit) begin
                  bus.cpu_ready <= 1'b1;
                  bus.cpu_hit   <= 1'b1;
                  bus.cpu_rdata <= hit_data;
                  state_q       <= RESP;
               end else begin
                  bus.mem_req   <= 1'b1;
                  bus.mem_we    <= we_q;
                  bus.mem_addr  <= {addr_q[31:2], 2'b00};
                  bus.mem_wdata <= wdata_q;
                  state_q       <= MEM;
               end
            end
            MEM: begin
               if (bus.mem_ready) begin
                  bus.mem_req   <= 1'b0;
                  bus.cpu_ready <= 1'b1;
                  bus.cpu_hit   <= hit_q;
                  bus.cpu_rdata <= we_q ? wdata_q : bus.mem_rdata;
                  if (!we_q) valid_q[idx][way_q] <= 1'b1;
                  state_q <= RESP;
               end
            end
            RESP: begin
               bus.cpu_ready <= 1'b0;
               bus.cpu_hit   <= 1'b0;
               state_q       <= IDLE;
            end
         endcase
      end
   end

   // Tag/data arrays carry no reset; only the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (state_q == LOOKUP && we_q && hit)
         data_q[hit_way][idx] <= wdata_q;
      if (refill) begin
         tag_q[way_q][idx]  <= tag;
         data_q[way_q][idx] <= bus.mem_rdata;
      end
   end
endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller against a recency/pointer cache model
// and a write-through backing memory model.
module tb_cache_controller;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   cache_controller_if bus();

   cache_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Cache model: which (tag) sits in which way, plus last-use time per way.
   bit          m_valid [4][256];
   logic [21:0] m_tag   [4][256];
   int          m_stamp [4][256];
   int          m_ptr   [256];
   int          tick = 0;
   logic [31:0] backing [logic [31:0]];

   function automatic logic [31:0] mem_word(input logic [31:0] wa);
      if (!backing.exists(wa)) backing[wa] = $urandom;
      return backing[wa];
   endfunction

   function automatic int m_lookup(input logic [31:0] a);
      int s = int'(a[9:2]);
      for (int w = 0; w < 4; w++)
         if (m_valid[w][s] && m_tag[w][s] == a[31:10]) return w;
      return -1;
   endfunction

   function automatic int m_victim(input int s);
      int v = 0;
      for (int w = 0; w < 4; w++) if (!m_valid[w][s]) return w;
`ifdef CACHE_LRU_EN
      for (int w = 1; w < 4; w++) if (m_stamp[w][s] < m_stamp[v][s]) v = w;
`else
      v = m_ptr[s];
`endif
      return v;
   endfunction

   task automatic m_touch(input int s, input int w);
      tick++;
      m_stamp[w][s] = tick;
   endtask

   task automatic m_reset();
      for (int s = 0; s < 256; s++) begin
         m_ptr[s] = 0;
         for (int w = 0; w < 4; w++) begin
            m_valid[w][s] = 1'b0;
            m_stamp[w][s] = 0;
         end
      end
   endtask

   task automatic do_req(input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input int delay,
                         input bit spur, output bit hit_o);
      int s = int'(addr[9:2]);
      int hw = m_lookup(addr);
      bit exp_hit = (hw >= 0);
      bit exp_mem = we || !exp_hit;
      logic [31:0] wa = {addr[31:2], 2'b00};
      logic [31:0] exp_rd;
      int resp_at = 2 + delay;
      int cyc = 0;
      bit got = 1'b0;
      bit saw_mem = 1'b0;
      bit bad_hold = 1'b0;
      int ready_cyc = -1;

      exp_rd = we ? wd : mem_word(wa);
      hit_o = 1'b0;
      @(negedge clk);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wd;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         bus.mem_ready = 1'b0;
         bus.mem_rdata = $urandom;
         if (bus.cpu_ready) begin
            got = 1'b1;
            ready_cyc = cyc;
            hit_o = bus.cpu_hit;
            check("cpu_hit", {31'b0, bus.cpu_hit}, {31'b0, exp_hit});
            if (!we) check("cpu_rdata", bus.cpu_rdata, exp_rd);
         end else if (bus.mem_req) begin
            if (!saw_mem) check("mem_req_lat", cyc, 2);
            saw_mem = 1'b1;
            if (bus.mem_we !== we || bus.mem_addr !== wa ||
                (we && bus.mem_wdata !== wd))
               bad_hold = 1'b1;
            if (cyc >= resp_at) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = exp_rd;
            end
         end else if (cyc == 1 && spur) begin
            bus.mem_ready = 1'b1;
         end
      end
      bus.cpu_req = 1'b0;
      bus.mem_ready = 1'b0;
      check("ready_seen", {31'b0, got}, 1);
      check("mem_used", {31'b0, saw_mem}, {31'b0, exp_mem});
      check("mem_fields", {31'b0, bad_hold}, 0);
      if (got) check("ready_lat", ready_cyc, exp_mem ? 3 + delay : 2);
      @(negedge clk);
      check("ready_pulse", {31'b0, bus.cpu_ready}, 0);
      check("mem_req_drop", {31'b0, bus.mem_req}, 0);

      if (we) begin
         backing[wa] = wd;
         if (exp_hit) m_touch(s, hw);
      end else if (exp_hit) begin
         m_touch(s, hw);
      end else begin
         int v = m_victim(s);
         m_valid[v][s] = 1'b1;
         m_tag[v][s] = addr[31:10];
         m_touch(s, v);
         m_ptr[s] = (m_ptr[s] + 1) % 4;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.cpu_req = 1'b0;
      bus.mem_ready = 1'b0;
      m_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] idx10(input int t);
      return (32'(t) << 10) | (32'd10 << 2);
   endfunction

   initial begin
      bit h;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.mem_rdata = '0;
      bus.mem_ready = 1'b0;
      m_reset();
      repeat (3) @(negedge clk);
      check("rst_cpu_ready", {31'b0, bus.cpu_ready}, 0);
      check("rst_cpu_hit", {31'b0, bus.cpu_hit}, 0);
      check("rst_cpu_rdata", bus.cpu_rdata, 0);
      check("rst_mem_req", {31'b0, bus.mem_req}, 0);
      check("rst_mem_we", {31'b0, bus.mem_we}, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      rst_n = 1'b1;

      backing[32'h0000_2C28] = 32'h1234;
      do_req(1'b0, 32'h0000_2C28, 0, 1, 1'b0, h);
      check("miss_first", {31'b0, h}, 0);
      do_req(1'b0, 32'h0000_2C28, 0, 0, 1'b1, h);
      check("hit_repeat", {31'b0, h}, 1);
      do_req(1'b1, 32'h0000_2C28, 32'hBEEF, 2, 1'b0, h);
      do_req(1'b0, 32'h0000_2C28, 0, 0, 1'b0, h);
      check("hit_after_wr", {31'b0, h}, 1);
      do_req(1'b1, 32'h0000_0400, 32'h5A5A_0001, 0, 1'b0, h);
      check("wr_miss", {31'b0, h}, 0);
      do_req(1'b0, 32'h0000_0400, 0, 0, 1'b0, h);
      check("no_alloc", {31'b0, h}, 0);

      // Reset while a refill is outstanding.
      @(negedge clk);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'h0000_5000;
      repeat (2) @(negedge clk);
      check("pre_rst_mem_req", {31'b0, bus.mem_req}, 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_mem_req", {31'b0, bus.mem_req}, 0);
      check("rst_mid_ready", {31'b0, bus.cpu_ready}, 0);
      bus.cpu_req = 1'b0;
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      do_req(1'b0, 32'h0000_5000, 0, 1, 1'b0, h);
      check("miss_after_rst", {31'b0, h}, 0);

      do_reset();
      for (int t = 1; t <= 4; t++) do_req(1'b0, idx10(t), 0, 0, 1'b0, h);
      do_req(1'b0, idx10(1), 0, 0, 1'b0, h);
      check("reread_A", {31'b0, h}, 1);
      do_req(1'b0, idx10(5), 0, 0, 1'b0, h);
      do_req(1'b0, idx10(1), 0, 0, 1'b0, h);
`ifdef CACHE_LRU_EN
      check("A_survives", {31'b0, h}, 1);
`else
      check("A_evicted", {31'b0, h}, 0);
`endif

      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         a = (32'($urandom_range(0, 7)) << 10) |
             (32'($urandom_range(8, 11)) << 2) | 32'($urandom_range(0, 3));
         do_req($urandom_range(0, 9) < 3, a, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 1) == 1, h);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter NSETS, default 256, meaning number of sets; index = cpu_addr[9:2], tag = cpu_addr[31:10].
REQ-002 SHALL have port clk  input  1  system clock; all state changes on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cpu_req  input  1  CPU request valid; held until cpu_ready.
REQ-005 SHALL have port cpu_we  input  1  request type: 0 = read, 1 = write.
REQ-006 SHALL have port cpu_addr  input  32  byte address.
REQ-007 SHALL have port cpu_wdata  input  32  write data.
REQ-008 SHALL have port cpu_rdata  output  32  read data, valid while cpu_ready=1.
REQ-009 SHALL have port cpu_ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have port cpu_hit  output  1  lookup hit flag, valid while cpu_ready=1.
REQ-011 SHALL have port mem_req  output  1  memory request; held until mem_ready.
REQ-012 SHALL have port mem_we  output  1  memory write (write-through) when 1, refill read when 0.
REQ-013 SHALL have port mem_addr  output  32  word-aligned memory address ({cpu_addr[31:2],2'b00}).
REQ-014 SHALL have port mem_wdata  output  32  memory write data.
REQ-015 SHALL have port mem_rdata  input  32  refill data, sampled when mem_ready=1.
REQ-016 SHALL have port mem_ready  input  1  memory completion, one cycle.

Function
REQ-017 SHALL hold 4 ways x NSETS entries of {valid, 22-bit tag, 32-bit data} plus per-set replacement state.
REQ-018 SHALL implement FSM IDLE, LOOKUP, MEM, RESP; IDLE->LOOKUP when cpu_req=1, latching cpu_we/addr/wdata.
REQ-019 SHALL in LOOKUP compare the latched tag against all 4 valid ways; at most one way matches by construction.
REQ-020 SHALL on read hit go LOOKUP->RESP, returning the hit way's data with cpu_hit=1 (latency: cpu_ready 2 cycles after acceptance).
REQ-021 SHALL on read miss go LOOKUP->MEM with mem_req=1, mem_we=0; on mem_ready fill victim way (valid=1, tag, mem_rdata), go RESP with cpu_rdata=mem_rdata, cpu_hit=0.
REQ-022 SHALL on write (hit or miss) go LOOKUP->MEM with mem_req=1, mem_we=1, mem_wdata=latched data; write hit also updates the hit way's data in LOOKUP; write miss does not allocate.
REQ-023 SHALL choose the victim as the lowest-index invalid way if any; otherwise per the replacement policy (REQ-032/033).
REQ-024 SHALL in RESP assert cpu_ready for exactly one cycle, then return to IDLE; a cpu_req high in that IDLE cycle is accepted normally (back-to-back).
REQ-025 SHALL keep mem_req and mem_addr/mem_we/mem_wdata stable from MEM entry until the mem_ready cycle; mem_req deasserts the cycle after mem_ready.
REQ-026 SHALL ignore mem_ready outside MEM and ignore cpu_req outside IDLE.
REQ-027 SHALL update replacement state of the set on every read hit, write hit and refill; never on write miss.

Reset
REQ-028 SHALL on rst_n=0, asynchronously: state=IDLE, all valid bits 0, replacement state 0, cpu_ready=0, cpu_hit=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-029 SHALL abandon any in-flight MEM transaction on reset with no array update; tag/data contents need not reset.
REQ-030 SHALL leave reset synchronously: first accept on the first posedge with rst_n=1 and cpu_req=1.

Configuration
REQ-031 SHALL use macro CACHE_LRU_EN to select the replacement policy.
REQ-032 SHALL with CACHE_LRU_EN defined keep 2-bit age per way per set (true LRU); accessed way age 0, younger ways +1; victim = age 3.
REQ-033 SHALL without CACHE_LRU_EN keep a 2-bit round-robin pointer per set; victim = pointer, pointer increments (mod 4) on refill only.

Verification
REQ-034 SHALL cover: reset, read 0x0000_2C28 -> mem_req, mem_we=0, mem_addr=0x0000_2C28; mem_rdata=0x1234 -> cpu_ready, cpu_hit=0, cpu_rdata=0x1234.
REQ-035 SHALL cover: repeat read 0x0000_2C28 -> cpu_ready 2 cycles after accept, cpu_hit=1, cpu_rdata=0x1234, no mem_req.
REQ-036 SHALL cover: write 0x0000_2C28 data 0xBEEF -> mem_req, mem_we=1, mem_wdata=0xBEEF; then read -> hit, 0xBEEF.
REQ-037 SHALL cover: 5 distinct tags on index 10, reads tags A,B,C,D, re-read A, read E -> with CACHE_LRU_EN E evicts B; without, E evicts A.
REQ-038 SHALL cover: rst_n low during MEM -> mem_req=0 immediately; subsequent read of same address misses.
REQ-039 SHALL cover: write miss to 0x0000_0400 then read -> read misses (no allocate).
